matrix_input_ctrl: RTL and testbench

Input subsystem stage sitting directly upstream of the top-level FSM/MMU controller and the matrix storage RAM. It takes a parsed token stream (one decoded number per token), captures matrix dimensions, requests a base address from the controller via the dims/addr handshake, then writes the header and the m·n elements into storage. Elements come either from further tokens (manual mode) or from an internal LFSR (generate mode).

---
 rtl/matrix_input_ctrl_pkg.sv | 25 ++
 rtl/matrix_input_ctrl_lfsr8.sv | 19 +
 rtl/matrix_input_ctrl.sv | 173 +++++++++++++++++
 tb/tb_matrix_input_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_input_ctrl_pkg.sv
// Shared definitions for the matrix input stage.
// Holds the FSM encoding, default limits and storage header layout.
package matrix_input_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_M,
    GET_N,
    REQ_ADDR,
    HDR_M,
    HDR_N,
    DATA,
    DONE,
    WAIT_OFF,
    ERROR
  } state_t;

  localparam int unsigned MAX_DIM_DEF = 5;
  localparam int unsigned MAX_VAL_DEF = 9;

  localparam logic [7:0] HDR_M_OFS = 8'd0;
  localparam logic [7:0] HDR_N_OFS = 8'd1;
  localparam logic [7:0] DATA_OFS  = 8'd2;

endpackage

// File: rtl/matrix_input_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances only when stepped.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (step) begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/matrix_input_ctrl.sv
// Captures matrix dimensions from a token stream, obtains a base address,
// then writes the header and elements (manual tokens or LFSR values) into storage.
module matrix_input_ctrl
  import matrix_input_ctrl_pkg::*;
#(
  parameter int unsigned MAX_DIM   = MAX_DIM_DEF,
  parameter int unsigned MAX_VAL   = MAX_VAL_DEF,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_is_gen_mode,
  input  logic        i_tok_valid,
  input  logic [7:0]  i_tok_data,
  output logic        o_tok_ready,
  output logic        o_dims_valid,
  output logic [31:0] o_dim_m,
  output logic [31:0] o_dim_n,
  input  logic        i_addr_ready,
  input  logic [7:0]  i_base_addr,
  output logic        o_wr_en,
  output logic [7:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_rx_done,
  output logic        o_error_flag
);

  localparam logic [7:0] MAX_DIM_B = 8'(MAX_DIM);
  localparam logic [7:0] MAX_VAL_B = 8'(MAX_VAL);

  state_t     state;
  logic       gen_mode;
  logic [7:0] dim_m;
  logic [7:0] dim_n;
  logic [7:0] base;
  logic [4:0] count;
  logic [4:0] idx;
  logic [7:0] lfsr_q;
  logic [7:0] nibble;
  logic [7:0] gen_val;
  logic       gen_step;

  assign o_dim_m = {24'd0, dim_m};
  assign o_dim_n = {24'd0, dim_n};

  assign o_tok_ready = (state == GET_M) || (state == GET_N) ||
                       ((state == DATA) && !gen_mode);

  // The LFSR advances only on cycles that actually issue a generated element.
  assign gen_step = i_en && gen_mode && ((state == HDR_N) || (state == DATA));

  assign nibble  = {4'd0, lfsr_q[3:0]};
  assign gen_val = (nibble > MAX_VAL_B) ? (nibble - (MAX_VAL_B + 8'd1)) : nibble;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (gen_step),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gen_mode     <= 1'b0;
      dim_m        <= 8'd0;
      dim_n        <= 8'd0;
      base         <= 8'd0;
      count        <= 5'd0;
      idx          <= 5'd0;
      o_dims_valid <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= 8'd0;
      o_wr_data    <= 8'd0;
      o_rx_done    <= 1'b0;
      o_error_flag <= 1'b0;
    end else begin
      o_wr_en   <= 1'b0;
      o_rx_done <= 1'b0;
      // Dropping i_en outside IDLE aborts the session ahead of any other event.
      if ((state != IDLE) && !i_en) begin
        state        <= IDLE;
        o_dims_valid <= 1'b0;
        o_error_flag <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (i_en) begin
              gen_mode <= i_is_gen_mode;
              state    <= GET_M;
            end
          end
          GET_M: begin
            if (i_tok_valid) begin
              if ((i_tok_data == 8'd0) || (i_tok_data > MAX_DIM_B)) begin
                state        <= ERROR;
                o_error_flag <= 1'b1;
              end else begin
                dim_m <= i_tok_data;
                state <= GET_N;
              end
            end
          end
          GET_N: begin
            if (i_tok_valid) begin
              if ((i_tok_data == 8'd0) || (i_tok_data > MAX_DIM_B)) begin
                state        <= ERROR;
                o_error_flag <= 1'b1;
              end else begin
                dim_n        <= i_tok_data;
                count        <= dim_m[4:0] * i_tok_data[4:0];
                o_dims_valid <= 1'b1;
                state        <= REQ_ADDR;
              end
            end
          end
          REQ_ADDR: begin
            if (i_addr_ready) begin
              base         <= i_base_addr;
              o_dims_valid <= 1'b0;
              o_wr_en      <= 1'b1;
              o_wr_addr    <= i_base_addr + HDR_M_OFS;
              o_wr_data    <= dim_m;
              state        <= HDR_M;
            end
          end
          HDR_M: begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= base + HDR_N_OFS;
            o_wr_data <= dim_n;
            state     <= HDR_N;
          end
          HDR_N: begin
            idx   <= 5'd0;
            state <= DATA;
            // Generated data follows the header with no bubble.
            if (gen_mode) begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= base + DATA_OFS;
              o_wr_data <= gen_val;
              idx       <= 5'd1;
              if (count == 5'd1) state <= DONE;
            end
          end
          DATA: begin
            if (gen_mode || i_tok_valid) begin
              if (!gen_mode && (i_tok_data > MAX_VAL_B)) begin
                state        <= ERROR;
                o_error_flag <= 1'b1;
              end else begin
                o_wr_en   <= 1'b1;
                o_wr_addr <= base + DATA_OFS + {3'd0, idx};
                o_wr_data <= gen_mode ? gen_val : i_tok_data;
                idx       <= idx + 5'd1;
                if (idx == count - 5'd1) state <= DONE;
              end
            end
          end
          DONE: begin
            o_rx_done <= 1'b1;
            state     <= WAIT_OFF;
          end
          WAIT_OFF, ERROR: begin
            state <= state;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_input_ctrl.sv
// Directed bench for matrix_input_ctrl: a table-driven manual session plus
// hand-written sequences for generation, errors, grant hold-off and aborts.
module tb_matrix_input_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_en;
  logic        i_is_gen_mode;
  logic        i_tok_valid;
  logic [7:0]  i_tok_data;
  logic        o_tok_ready;
  logic        o_dims_valid;
  logic [31:0] o_dim_m;
  logic [31:0] o_dim_n;
  logic        i_addr_ready;
  logic [7:0]  i_base_addr;
  logic        o_wr_en;
  logic [7:0]  o_wr_addr;
  logic [7:0]  o_wr_data;
  logic        o_rx_done;
  logic        o_error_flag;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] lfsr_m = 8'hA5;

  typedef struct {
    logic       en, gen, tv;
    logic [7:0] td;
    logic       ar;
    logic [7:0] base;
    logic       x_rdy, x_dv, x_we;
    logic [7:0] x_wa, x_wd;
    logic       x_done, x_err;
    logic [7:0] x_m, x_n;
  } vec_t;

  vec_t vecs[17];

  always #5 clk = ~clk;

  matrix_input_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (i_en),
    .i_is_gen_mode(i_is_gen_mode),
    .i_tok_valid  (i_tok_valid),
    .i_tok_data   (i_tok_data),
    .o_tok_ready  (o_tok_ready),
    .o_dims_valid (o_dims_valid),
    .o_dim_m      (o_dim_m),
    .o_dim_n      (o_dim_n),
    .i_addr_ready (i_addr_ready),
    .i_base_addr  (i_base_addr),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_rx_done    (o_rx_done),
    .o_error_flag (o_error_flag)
  );

  function automatic vec_t mk(input logic en, gen, tv, input logic [7:0] td,
                              input logic ar, input logic [7:0] base,
                              input logic rdy, dv, we, input logic [7:0] wa, wd,
                              input logic done, err, input logic [7:0] m, n);
    vec_t v;
    v.en = en; v.gen = gen; v.tv = tv; v.td = td; v.ar = ar; v.base = base;
    v.x_rdy = rdy; v.x_dv = dv; v.x_we = we; v.x_wa = wa; v.x_wd = wd;
    v.x_done = done; v.x_err = err; v.x_m = m; v.x_n = n;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, gen, tv, input logic [7:0] td,
                               input logic ar, input logic [7:0] base);
    i_en          = en;
    i_is_gen_mode = gen;
    i_tok_valid   = tv;
    i_tok_data    = td;
    i_addr_ready  = ar;
    i_base_addr   = base;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic checkWrite(input string name, input logic [7:0] addr, input logic [7:0] data);
    checkOutput({name, ".we"}, o_wr_en, 1);
    checkOutput({name, ".addr"}, o_wr_addr, addr);
    checkOutput({name, ".data"}, o_wr_data, data);
  endtask

  // Reference generator: value from the low nibble folded into 0..9, then step.
  task automatic modelGen(output logic [7:0] v);
    logic [7:0] nib;
    nib = {4'd0, lfsr_m[3:0]};
    v = (nib > 8'd9) ? nib - 8'd10 : nib;
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] a;

    // Manual 2x3 session at base 0x10, one row per cycle.
    vecs[0]  = mk(1,0,0,8'd0,0,8'h00, 0,0,0,8'h00,8'd0,0,0,8'd0,8'd0);
    vecs[1]  = mk(1,0,1,8'd2,0,8'h00, 1,0,0,8'h00,8'd0,0,0,8'd0,8'd0);
    vecs[2]  = mk(1,0,1,8'd3,0,8'h00, 1,0,0,8'h00,8'd0,0,0,8'd2,8'd0);
    vecs[3]  = mk(1,0,0,8'd0,0,8'h00, 0,1,0,8'h00,8'd0,0,0,8'd2,8'd3);
    vecs[4]  = mk(1,0,0,8'd0,1,8'h10, 0,1,0,8'h00,8'd0,0,0,8'd2,8'd3);
    vecs[5]  = mk(1,0,0,8'd0,0,8'h00, 0,0,1,8'h10,8'd2,0,0,8'd2,8'd3);
    vecs[6]  = mk(1,0,0,8'd0,0,8'h00, 0,0,1,8'h11,8'd3,0,0,8'd2,8'd3);
    vecs[7]  = mk(1,0,1,8'd1,0,8'h00, 1,0,0,8'h00,8'd0,0,0,8'd2,8'd3);
    vecs[8]  = mk(1,0,1,8'd2,0,8'h00, 1,0,1,8'h12,8'd1,0,0,8'd2,8'd3);
    vecs[9]  = mk(1,0,1,8'd3,0,8'h00, 1,0,1,8'h13,8'd2,0,0,8'd2,8'd3);
    vecs[10] = mk(1,0,1,8'd4,0,8'h00, 1,0,1,8'h14,8'd3,0,0,8'd2,8'd3);
    vecs[11] = mk(1,0,1,8'd5,0,8'h00, 1,0,1,8'h15,8'd4,0,0,8'd2,8'd3);
    vecs[12] = mk(1,0,1,8'd6,0,8'h00, 1,0,1,8'h16,8'd5,0,0,8'd2,8'd3);
    vecs[13] = mk(1,0,0,8'd0,0,8'h00, 0,0,1,8'h17,8'd6,0,0,8'd2,8'd3);
    vecs[14] = mk(1,0,0,8'd0,0,8'h00, 0,0,0,8'h00,8'd0,1,0,8'd2,8'd3);
    vecs[15] = mk(0,0,0,8'd0,0,8'h00, 0,0,0,8'h00,8'd0,0,0,8'd2,8'd3);
    vecs[16] = mk(0,0,0,8'd0,0,8'h00, 0,0,0,8'h00,8'd0,0,0,8'd2,8'd3);

    rst_n = 1'b0;
    applyStimulus(0,0,0,8'd0,0,8'h00);
    repeat (2) tick;
    checkOutput("rst.rdy",  o_tok_ready, 0);
    checkOutput("rst.dv",   o_dims_valid, 0);
    checkOutput("rst.m",    o_dim_m, 0);
    checkOutput("rst.n",    o_dim_n, 0);
    checkOutput("rst.we",   o_wr_en, 0);
    checkOutput("rst.addr", o_wr_addr, 0);
    checkOutput("rst.data", o_wr_data, 0);
    checkOutput("rst.done", o_rx_done, 0);
    checkOutput("rst.err",  o_error_flag, 0);
    rst_n = 1'b1;
    tick;

    $display("[TB] manual 2x3 table");
    for (int i = 0; i < 17; i++) begin
      checkOutput($sformatf("t1[%0d].rdy", i),  o_tok_ready,  vecs[i].x_rdy);
      checkOutput($sformatf("t1[%0d].dv", i),   o_dims_valid, vecs[i].x_dv);
      checkOutput($sformatf("t1[%0d].we", i),   o_wr_en,      vecs[i].x_we);
      if (vecs[i].x_we) begin
        checkOutput($sformatf("t1[%0d].addr", i), o_wr_addr, vecs[i].x_wa);
        checkOutput($sformatf("t1[%0d].data", i), o_wr_data, vecs[i].x_wd);
      end
      checkOutput($sformatf("t1[%0d].done", i), o_rx_done,    vecs[i].x_done);
      checkOutput($sformatf("t1[%0d].err", i),  o_error_flag, vecs[i].x_err);
      checkOutput($sformatf("t1[%0d].m", i),    o_dim_m,      {24'd0, vecs[i].x_m});
      checkOutput($sformatf("t1[%0d].n", i),    o_dim_n,      {24'd0, vecs[i].x_n});
      applyStimulus(vecs[i].en, vecs[i].gen, vecs[i].tv, vecs[i].td, vecs[i].ar, vecs[i].base);
      tick;
    end

    $display("[TB] generate 5x5 at base F0");
    applyStimulus(1,1,0,8'd0,0,8'h00); tick;
    applyStimulus(1,1,1,8'd5,0,8'h00); tick;
    applyStimulus(1,1,1,8'd5,0,8'h00); tick;
    checkOutput("t2.dv", o_dims_valid, 1);
    checkOutput("t2.m",  o_dim_m, 5);
    checkOutput("t2.n",  o_dim_n, 5);
    applyStimulus(1,1,0,8'd0,1,8'hF0); tick;
    applyStimulus(1,1,0,8'd0,0,8'h00);
    for (int i = 0; i < 27; i++) begin
      a = 8'hF0 + 8'(i);
      if (i < 2) v = 8'd5;
      else modelGen(v);
      checkWrite($sformatf("t2[%0d]", i), a, v);
      checkOutput($sformatf("t2[%0d].range", i), (o_wr_data <= 8'd9), 1);
      checkOutput($sformatf("t2[%0d].rdy", i), o_tok_ready, 0);
      checkOutput($sformatf("t2[%0d].done", i), o_rx_done, 0);
      tick;
    end
    checkOutput("t2.done", o_rx_done, 1);
    checkOutput("t2.we_after", o_wr_en, 0);
    applyStimulus(0,0,0,8'd0,0,8'h00); tick;
    checkOutput("t2.done_clr", o_rx_done, 0);
    tick;

    $display("[TB] dimension errors");
    applyStimulus(1,0,0,8'd0,0,8'h00); tick;
    checkOutput("t3.getm_rdy", o_tok_ready, 1);
    applyStimulus(1,0,1,8'd0,0,8'h00); tick;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t3a[%0d].err", i), o_error_flag, 1);
      checkOutput($sformatf("t3a[%0d].dv", i),  o_dims_valid, 0);
      checkOutput($sformatf("t3a[%0d].rdy", i), o_tok_ready, 0);
      applyStimulus(1,0,1,8'd3,1,8'h20); tick;
    end
    applyStimulus(0,0,0,8'd0,0,8'h00); tick;
    checkOutput("t3a.err_clr", o_error_flag, 0);
    checkOutput("t3a.idle_rdy", o_tok_ready, 0);
    applyStimulus(1,0,0,8'd0,0,8'h00); tick;
    applyStimulus(1,0,1,8'd2,0,8'h00); tick;
    checkOutput("t3b.getn_rdy", o_tok_ready, 1);
    applyStimulus(1,0,1,8'd6,0,8'h00); tick;
    checkOutput("t3b.err", o_error_flag, 1);
    checkOutput("t3b.dv",  o_dims_valid, 0);
    applyStimulus(0,0,0,8'd0,0,8'h00); tick;
    checkOutput("t3b.err_clr", o_error_flag, 0);

    $display("[TB] abort racing a grant");
    applyStimulus(1,0,0,8'd0,0,8'h00); tick;
    applyStimulus(1,0,1,8'd2,0,8'h00); tick;
    applyStimulus(1,0,1,8'd2,0,8'h00); tick;
    checkOutput("t3c.dv", o_dims_valid, 1);
    applyStimulus(0,0,0,8'd0,1,8'h33); tick;
    checkOutput("t3c.dv_clr", o_dims_valid, 0);
    checkOutput("t3c.we", o_wr_en, 0);
    applyStimulus(0,0,0,8'd0,0,8'h00); tick;
    checkOutput("t3c.we2", o_wr_en, 0);

    $display("[TB] bad element value");
    applyStimulus(1,0,0,8'd0,0,8'h00); tick;
    applyStimulus(1,0,1,8'd1,0,8'h00); tick;
    applyStimulus(1,0,1,8'd2,0,8'h00); tick;
    applyStimulus(1,0,0,8'd0,1,8'h40); tick;
    checkWrite("t4.hm", 8'h40, 8'd1);
    applyStimulus(1,0,0,8'd0,0,8'h00); tick;
    checkWrite("t4.hn", 8'h41, 8'd2);
    tick;
    checkOutput("t4.data_rdy", o_tok_ready, 1);
    applyStimulus(1,0,1,8'd7,0,8'h00); tick;
    checkWrite("t4.e0", 8'h42, 8'd7);
    applyStimulus(1,0,1,8'd12,0,8'h00); tick;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t4[%0d].err", i), o_error_flag, 1);
      checkOutput($sformatf("t4[%0d].we", i),  o_wr_en, 0);
      applyStimulus(1,0,0,8'd0,0,8'h00); tick;
    end
    applyStimulus(0,0,0,8'd0,0,8'h00); tick;
    checkOutput("t4.err_clr", o_error_flag, 0);

    $display("[TB] grant hold-off and mid-data abort");
    applyStimulus(1,0,0,8'd0,0,8'h00); tick;
    applyStimulus(1,0,1,8'd3,1,8'h55); tick;
    checkOutput("t5.early_dv", o_dims_valid, 0);
    applyStimulus(1,0,1,8'd4,0,8'h00); tick;
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("t5[%0d].dv", i), o_dims_valid, 1);
      checkOutput($sformatf("t5[%0d].m", i),  o_dim_m, 3);
      checkOutput($sformatf("t5[%0d].n", i),  o_dim_n, 4);
      checkOutput($sformatf("t5[%0d].we", i), o_wr_en, 0);
      applyStimulus(1,0,0,8'd0,0,8'h00); tick;
    end
    applyStimulus(1,0,0,8'd0,1,8'hFE); tick;
    checkOutput("t5.dv_drop", o_dims_valid, 0);
    checkWrite("t5.hm", 8'hFE, 8'd3);
    applyStimulus(1,0,0,8'd0,0,8'h00); tick;
    checkWrite("t5.hn", 8'hFF, 8'd4);
    tick;
    applyStimulus(1,0,1,8'd1,0,8'h00); tick;
    checkWrite("t5.e0", 8'h00, 8'd1);
    applyStimulus(0,0,1,8'd2,0,8'h00); tick;
    checkOutput("t6.abort_we", o_wr_en, 0);
    checkOutput("t6.abort_rdy", o_tok_ready, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t6[%0d].done", i), o_rx_done, 0);
      checkOutput($sformatf("t6[%0d].we", i), o_wr_en, 0);
      applyStimulus(0,0,0,8'd0,0,8'h00); tick;
    end

    $display("[TB] restart in generate mode 1x1");
    applyStimulus(1,1,0,8'd0,0,8'h00); tick;
    checkOutput("t6.getm_rdy", o_tok_ready, 1);
    applyStimulus(1,0,1,8'd1,0,8'h00); tick;
    applyStimulus(1,0,1,8'd1,0,8'h00); tick;
    checkOutput("t6.dv", o_dims_valid, 1);
    applyStimulus(1,0,0,8'd0,1,8'h80); tick;
    applyStimulus(1,0,0,8'd0,0,8'h00);
    checkWrite("t6.hm", 8'h80, 8'd1);
    tick;
    checkWrite("t6.hn", 8'h81, 8'd1);
    tick;
    modelGen(v);
    checkWrite("t6.e0", 8'h82, v);
    checkOutput("t6.data_rdy", o_tok_ready, 0);
    tick;
    checkOutput("t6.done", o_rx_done, 1);
    checkOutput("t6.we_after", o_wr_en, 0);
    applyStimulus(0,0,0,8'd0,0,8'h00); tick;
    checkOutput("t6.done_clr", o_rx_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
